id_ex_ctrl_pipe: RTL and testbench
==================================

# id_ex_ctrl_pipe

Parametrised ID/EX control-bundle pipeline register with stall, flush and multi-cycle bubble injection. It sits between the decoder/controller and the EX stage of the pipelined CPU. It latches the WB/MEM/EX control fields each cycle, holds them on a downstream stall, and zeroes them on a flush. On a hazard-unit request it injects a programmable run of 1..2^BUB_W-1 bubbles while telling IF/ID to hold the waiting instruction.

## Interface
Parameters:
- `ALUOP_W`, 5: ALU operation field width
- `WDSEL_W`, 3: write-back data select width
- `NPCOP_W`, 3: next-PC operation width
- `BUB_W`, 2: bubble-length field width; max run = 2^BUB_W-1

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  EX not advancing: hold register and counter
- `flush`  in  1  squash: load a bubble, abort any injection
- `bubble_req`  in  1  start bubble run (level, sampled in RUN only)
- `bubble_len`  in  BUB_W  bubbles to inject; 0 = no request
- `CTRL_RegWrite`, `CTRL_MemWrite`, `CTRL_ALUSrc`  in  1 each  decoded controls
- `CTRL_WDSel`  in  WDSEL_W;  `CTRL_ALUOp`  in  ALUOP_W;  `CTRL_NPCOp`  in  NPCOP_W
- `ID_EX_RegWrite`, `ID_EX_MemWrite`, `ID_EX_ALUSrc`  out  1 each  registered controls
- `ID_EX_WDSel`  out  WDSEL_W;  `ID_EX_ALUOp`  out  ALUOP_W;  `ID_EX_NPCOp`  out  NPCOP_W
- `ID_EX_valid`  out  1  1 = real instruction, 0 = bubble
- `id_hold`  out  1  combinational; IF/ID must not advance this cycle
- `bubble_count`  out  32  bubbles injected (only with `CTRL_PIPE_STATS_EN`)

## Operation
- Bubble = all `ID_EX_*` fields 0 and `ID_EX_valid`=0.
- States: RUN, INJECT. Remaining counter `rem` is BUB_W bits wide.
- Reset: state RUN, `rem`=0, all outputs 0, `ID_EX_valid`=0, `bubble_count`=0.
- RUN, per edge, in priority order:
  - `flush`: load bubble.
  - else `stall`: hold all registers. A concurrent `bubble_req` is ignored and must be re-asserted.
  - else `bubble_req` && `bubble_len`!=0: load bubble and set `rem`=`bubble_len`-1. Go to INJECT if `rem`!=0, else stay in RUN.
  - else: load `CTRL_*` inputs and set `ID_EX_valid`=1.
- INJECT, per edge, in priority order:
  - `flush`: load bubble, set `rem`=0, go to RUN.
  - else `stall`: hold registers and `rem`.
  - else: load bubble and set `rem`=`rem`-1. Go to RUN when `rem` was 1.
  - `bubble_req` is ignored in INJECT.
- `id_hold` = (RUN && `bubble_req` && `bubble_len`!=0 && !`flush` && !`stall`) || (INJECT && !`flush`).
- Total bubbles per accepted request = `bubble_len`, stalls excluded. The held ID instruction loads on the first RUN edge after the run ends.

## Timing
- Latency: inputs appear on `ID_EX_*` 1 cycle after the edge at which they are sampled.
- `id_hold` is combinational from `state`, `bubble_req`, `bubble_len`, `flush` and `stall`. It is valid in the same cycle as the request so that IF/ID freezes on that same edge.
- Request at edge k with `bubble_len`=3 and no stall:
  - bubbles are visible after edges k, k+1 and k+2;
  - the held instruction is visible after edge k+3;
  - `id_hold` is high in cycles k..k+2.
- Stall in INJECT extends the run 1 cycle per stalled cycle. Output stays a bubble and `id_hold` stays high.
- `rst` overrides everything at any point, including mid-INJECT. Outputs return to reset values on the next edge.

## Configuration
- `CTRL_PIPE_STATS_EN` defined:
  - `bubble_count` port exists.
  - It increments by 1 on every edge that loads a bubble due to `bubble_req`/INJECT. Flush bubbles and stalled edges do not count.
  - It saturates at 32'hFFFF_FFFF and is cleared by `rst`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Pass-through: RegWrite=1, ALUOp=5'h0A, NPCOp=3'b010, no stall/flush -> next cycle outputs equal the inputs, `ID_EX_valid`=1, `id_hold`=0.
- Load-use: `bubble_req`=1, `bubble_len`=1 for one cycle -> one bubble, `id_hold` high 1 cycle, then the held inputs load. With stats, `bubble_count`=1.
- Run of 3 with stall: `bubble_len`=3, then `stall` for 2 cycles during the 2nd bubble -> 3 bubbles over 5 cycles, `id_hold` high 5 cycles. With stats, `bubble_count`=3.
- Flush mid-INJECT: `bubble_len`=3, `flush` on the 2nd bubble edge -> bubble, state RUN, `id_hold`=0 in the flush cycle, next inputs load the following edge.
- Priority: `stall`=1 and `bubble_req`=1 in RUN -> outputs held, `id_hold`=0, no run starts. `flush`=1 and `stall`=1 -> bubble loaded.
- Reset mid-run: `rst` during INJECT with `rem`=2 -> next edge all outputs 0, `id_hold`=0, `bubble_count`=0.

Source files
------------

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control-bundle pipeline register with stall, flush and multi-cycle bubble injection.
// Optional bubble statistics counter enabled by defining CTRL_PIPE_STATS_EN.
module id_ex_ctrl_pipe #(
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned WDSEL_W = 3,
  parameter int unsigned NPCOP_W = 3,
  parameter int unsigned BUB_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               bubble_req,
  input  logic [BUB_W-1:0]   bubble_len,
  input  logic               CTRL_RegWrite,
  input  logic               CTRL_MemWrite,
  input  logic               CTRL_ALUSrc,
  input  logic [WDSEL_W-1:0] CTRL_WDSel,
  input  logic [ALUOP_W-1:0] CTRL_ALUOp,
  input  logic [NPCOP_W-1:0] CTRL_NPCOp,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_ALUSrc,
  output logic [WDSEL_W-1:0] ID_EX_WDSel,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [NPCOP_W-1:0] ID_EX_NPCOp,
  output logic               ID_EX_valid,
`ifdef CTRL_PIPE_STATS_EN
  output logic [31:0]        bubble_count,
`endif
  output logic               id_hold
);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_INJECT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [BUB_W-1:0] rem, rem_nxt;
  logic             load_bubble_c;
  logic             load_ctrl_c;
  logic             req_bubble_c;

  // Next-state, remaining-count and load decisions; id_hold is the only combinational output.
  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    load_bubble_c = 1'b0;
    load_ctrl_c   = 1'b0;
    req_bubble_c  = 1'b0;
    id_hold       = 1'b0;
    case (state)
      S_RUN: begin
        if (flush) begin
          load_bubble_c = 1'b1;
        end else if (stall) begin
          load_bubble_c = 1'b0;
        end else if (bubble_req && (bubble_len != '0)) begin
          load_bubble_c = 1'b1;
          req_bubble_c  = 1'b1;
          id_hold       = 1'b1;
          rem_nxt       = bubble_len - BUB_W'(1);
          if (bubble_len != BUB_W'(1)) state_nxt = S_INJECT;
        end else begin
          load_ctrl_c = 1'b1;
        end
      end
      S_INJECT: begin
        if (flush) begin
          load_bubble_c = 1'b1;
          rem_nxt       = '0;
          state_nxt     = S_RUN;
        end else if (stall) begin
          id_hold = 1'b1;
        end else begin
          load_bubble_c = 1'b1;
          req_bubble_c  = 1'b1;
          id_hold       = 1'b1;
          rem_nxt       = rem - BUB_W'(1);
          if (rem == BUB_W'(1)) state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_RUN;
        rem_nxt   = '0;
      end
    endcase
  end

  // State and remaining-bubble register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Control bundle register: bubble, load, or hold (stall).
  always_ff @(posedge clk) begin
    if (rst || load_bubble_c) begin
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_WDSel    <= '0;
      ID_EX_ALUOp    <= '0;
      ID_EX_NPCOp    <= '0;
      ID_EX_valid    <= 1'b0;
    end else if (load_ctrl_c) begin
      ID_EX_RegWrite <= CTRL_RegWrite;
      ID_EX_MemWrite <= CTRL_MemWrite;
      ID_EX_ALUSrc   <= CTRL_ALUSrc;
      ID_EX_WDSel    <= CTRL_WDSel;
      ID_EX_ALUOp    <= CTRL_ALUOp;
      ID_EX_NPCOp    <= CTRL_NPCOp;
      ID_EX_valid    <= 1'b1;
    end
  end

`ifdef CTRL_PIPE_STATS_EN
  // Saturating count of hazard-requested bubbles; flush bubbles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (req_bubble_c && (bubble_count != 32'hFFFF_FFFF)) begin
      bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Self-checking bench for id_ex_ctrl_pipe: directed test-plan steps then randomized cycles
// against a bubble-run reference model.
module tb_id_ex_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst, stall, flush, bubble_req;
  logic [1:0]  bubble_len;
  logic [13:0] ctrl_v;
  logic        o_regwrite, o_memwrite, o_alusrc, o_valid, id_hold;
  logic [2:0]  o_wdsel, o_npcop;
  logic [4:0]  o_aluop;
`ifdef CTRL_PIPE_STATS_EN
  logic [31:0] bubble_count;
`endif

  int tests = 0;
  int failed = 0;

  // Reference model: expected outputs plus bubbles still owed in the current run.
  logic [14:0] m_out;
  int          m_left;
  logic [31:0] m_cnt;
  bit          m_known = 1'b0;

  always #5 clk = ~clk;

  id_ex_ctrl_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .bubble_req(bubble_req), .bubble_len(bubble_len),
    .CTRL_RegWrite(ctrl_v[13]), .CTRL_MemWrite(ctrl_v[12]), .CTRL_ALUSrc(ctrl_v[11]),
    .CTRL_WDSel(ctrl_v[10:8]), .CTRL_ALUOp(ctrl_v[7:3]), .CTRL_NPCOp(ctrl_v[2:0]),
    .ID_EX_RegWrite(o_regwrite), .ID_EX_MemWrite(o_memwrite), .ID_EX_ALUSrc(o_alusrc),
    .ID_EX_WDSel(o_wdsel), .ID_EX_ALUOp(o_aluop), .ID_EX_NPCOp(o_npcop),
    .ID_EX_valid(o_valid),
`ifdef CTRL_PIPE_STATS_EN
    .bubble_count(bubble_count),
`endif
    .id_hold(id_hold)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check id_hold before the edge, advance model, check outputs after.
  task automatic step(input string tag, input logic r, input logic st, input logic fl,
                      input logic rq, input logic [1:0] len, input logic [13:0] c);
    logic hold_exp;
    @(negedge clk);
    rst = r; stall = st; flush = fl; bubble_req = rq; bubble_len = len; ctrl_v = c;
    #1;
    hold_exp = ((m_left == 0) && rq && (len != 2'd0) && !fl && !st) || ((m_left > 0) && !fl);
    if (m_known && !r) check({tag, ".hold"}, 32'(id_hold), 32'(hold_exp));
    @(posedge clk);
    if (r) begin
      m_out = '0; m_left = 0; m_cnt = '0; m_known = 1'b1;
    end else if (fl) begin
      m_out = '0; m_left = 0;
    end else if (st) begin
      m_out = m_out;
    end else if (m_left > 0) begin
      m_out = '0; m_left--;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end else if (rq && (len != 2'd0)) begin
      m_out = '0; m_left = int'(len) - 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end else begin
      m_out = {1'b1, c};
    end
    #1;
    if (m_known) begin
      check({tag, ".out"}, 32'({o_valid, o_regwrite, o_memwrite, o_alusrc, o_wdsel, o_aluop, o_npcop}),
            32'(m_out));
`ifdef CTRL_PIPE_STATS_EN
      check({tag, ".cnt"}, bubble_count, m_cnt);
`endif
    end
  endtask

  localparam logic [13:0] PT   = {1'b1, 1'b0, 1'b0, 3'b000, 5'h0A, 3'b010};
  localparam logic [13:0] HELD = {1'b0, 1'b1, 1'b1, 3'b101, 5'h13, 3'b001};
  localparam logic [13:0] NXT  = {1'b1, 1'b1, 1'b0, 3'b011, 5'h07, 3'b100};

  initial begin
    m_out = '0; m_left = 0; m_cnt = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; bubble_req = 1'b0; bubble_len = 2'd0; ctrl_v = '0;
    // Reset state
    step("reset0", 1, 0, 0, 0, 2'd0, PT);
    step("reset1", 1, 0, 0, 0, 2'd0, PT);
    check("reset.hold", 32'(id_hold), 32'd0);
    // Pass-through
    step("pass", 0, 0, 0, 0, 2'd0, PT);
    // Load-use: one bubble, then held instruction
    step("lu.req", 0, 0, 0, 1, 2'd1, HELD);
    step("lu.load", 0, 0, 0, 0, 2'd0, HELD);
    // Run of 3 with 2-cycle stall
    step("r3.req", 0, 0, 0, 1, 2'd3, HELD);
    step("r3.st1", 0, 1, 0, 0, 2'd0, HELD);
    step("r3.st2", 0, 1, 0, 0, 2'd0, HELD);
    step("r3.b2", 0, 0, 0, 1, 2'd3, HELD);
    step("r3.b3", 0, 0, 0, 0, 2'd0, HELD);
    step("r3.load", 0, 0, 0, 0, 2'd0, HELD);
    // Flush mid-inject
    step("fl.req", 0, 0, 0, 1, 2'd3, HELD);
    step("fl.flush", 0, 0, 1, 0, 2'd0, HELD);
    step("fl.next", 0, 0, 0, 0, 2'd0, NXT);
    // Priority: stall beats request; flush beats stall
    step("pr.stall", 0, 1, 0, 1, 2'd2, PT);
    step("pr.after", 0, 0, 0, 0, 2'd0, PT);
    step("pr.flst", 0, 1, 1, 0, 2'd0, NXT);
    // Reset mid-run with two bubbles remaining
    step("rm.req", 0, 0, 0, 1, 2'd3, HELD);
    step("rm.rst", 1, 0, 0, 0, 2'd0, HELD);
    step("rm.idle", 0, 0, 0, 0, 2'd0, NXT);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 9) < 3),
           2'($urandom),
           14'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
